// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: copies LEN bytes from page {src,00} into OAM when the CPU writes REG_ADDR,
// blocking CPU main-bus access while the copy runs.
module oam_dma_ctrl #(
    parameter logic [15:0] REG_ADDR = 16'hFF46,
    parameter int          LEN      = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic [7:0]  hi_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active
);
    typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} state_t;
    typedef enum logic [1:0] {SEL_FF, SEL_BUS, SEL_HI, SEL_REG} sel_t;

    state_t     state_q, state_d;
    sel_t       sel_q, sel_d;
    logic [7:0] src_q, src_d, reg_q, reg_d, idx_q, idx_d, pidx_q;
    logic       pend_q;
    logic       is_reg, is_hi, is_main, active, reg_wr, last;

    assign is_reg  = cpu_addr == REG_ADDR;
    assign is_hi   = (&cpu_addr[15:8]) && !is_reg;
    assign is_main = !(&cpu_addr[15:8]);
    assign active  = state_q != IDLE;
    assign reg_wr  = cpu_we && is_reg;
    assign last    = idx_q == 8'(LEN - 1);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        reg_d   = reg_q;
        idx_d   = idx_q;
        if (reg_wr) begin
            state_d = START;
            src_d   = cpu_wdata >= 8'hE0 ? cpu_wdata - 8'h20 : cpu_wdata;
            reg_d   = cpu_wdata;
            idx_d   = '0;
        end else if (state_q == START) begin
            state_d = XFER;
        end else if (state_q == XFER) begin
            state_d = last ? DRAIN : XFER;
            idx_d   = last ? '0 : idx_q + 8'd1;
        end else if (state_q == DRAIN) begin
            state_d = IDLE;
        end
        // read source is frozen at request time so a finishing DMA cannot unblock it
        sel_d = (!cpu_rd || reg_wr) ? SEL_FF :
                is_reg              ? SEL_REG :
                is_hi               ? SEL_HI :
                active              ? SEL_FF : SEL_BUS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_FF;
            src_q   <= '0;
            reg_q   <= '0;
            idx_q   <= '0;
            pidx_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            src_q   <= src_d;
            reg_q   <= reg_d;
            idx_q   <= idx_d;
            pidx_q  <= idx_q;
            pend_q  <= state_q == XFER;
        end
    end

    assign dma_active = active;
    assign bus_addr   = state_q == XFER ? {src_q, idx_q} : cpu_addr;
    assign bus_rd     = !rst && (state_q == XFER || (!active && cpu_rd && is_main));
    assign bus_we     = !rst && !active && cpu_we && is_main;
    assign bus_wdata  = cpu_wdata;
    // suppress the write landing on the reset edge so an abort leaves OAM untouched
    assign oam_we     = pend_q && !rst;
    assign oam_addr   = pidx_q;
    assign oam_wdata  = bus_rdata;
    assign cpu_rdata  = sel_q == SEL_BUS ? bus_rdata :
                        sel_q == SEL_HI  ? hi_rdata :
                        sel_q == SEL_REG ? reg_q : 8'hFF;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed stimulus with expected OAM writes and CPU read data queued
// up front; a negedge monitor pops and compares whenever the DUT presents a result.
module tb_oam_dma_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rd = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata, bus_wdata, oam_addr, oam_wdata;
    logic [15:0] bus_addr;
    logic        bus_rd, bus_we, oam_we, dma_active;
    logic [7:0]  bus_rdata = '0, hi_rdata = '0, hi_val = 8'hA7;
    logic        rd_ph = 1'b0;

    int          checks = 0, failures = 0, oam_cnt = 0;
    logic [15:0] oam_exp_q[$];
    logic [7:0]  rd_exp_q[$];
    logic [7:0]  oam_m[256];

    oam_dma_ctrl dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .bus_addr(bus_addr), .bus_rd(bus_rd),
        .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .hi_rdata(hi_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [15:0] a);
        return 8'(a[7:0] * 7 + a[15:8] * 13 + 1);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // memory models with one-cycle read latency; rd_ph marks a CPU read data phase
    always @(posedge clk) begin
        if (bus_rd) bus_rdata <= rom(bus_addr);
        hi_rdata <= hi_val;
        rd_ph    <= cpu_rd && !(cpu_we && cpu_addr == 16'hFF46) && !rst;
    end

    always @(negedge clk) begin : mon
        logic [15:0] e;
        if (oam_we) begin
            oam_cnt++;
            oam_m[oam_addr] = oam_wdata;
            if (oam_exp_q.size() == 0) chk("oam_unexpected_write", {oam_addr, oam_wdata}, 16'hXXXX);
            else begin
                e = oam_exp_q.pop_front();
                chk("oam_write", {oam_addr, oam_wdata}, e);
            end
        end
        if (rd_ph) begin
            if (rd_exp_q.size() == 0) chk("cpu_rdata_unexpected", {8'h00, cpu_rdata}, 16'hXXXX);
            else chk("cpu_rdata", {8'h00, cpu_rdata}, {8'h00, rd_exp_q.pop_front()});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_xfer(input logic [7:0] pg, input int n);
        for (int i = 0; i < n; i++) oam_exp_q.push_back({8'(i), rom({pg, 8'(i)})});
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_we = 1'b1; cpu_wdata = d;
        tick;
        cpu_we = 1'b0;
    endtask

    task automatic cpu_rdx(input logic [15:0] a, input logic [7:0] exp, input logic exp_bus);
        cpu_addr = a; cpu_rd = 1'b1;
        rd_exp_q.push_back(exp);
        #1;
        chk("cpu_read_bus_strobe", {15'd0, bus_rd && bus_addr == a}, {15'd0, exp_bus});
        tick;
        cpu_rd = 1'b0;
    endtask

    initial begin
        int n, k, bad, c0;
        logic found;
        for (int i = 0; i < 256; i++) oam_m[i] = 8'h00;
        tick; tick;
        chk("rst_dma_active", {15'd0, dma_active}, 16'd0);
        chk("rst_cpu_rdata", {8'h00, cpu_rdata}, 16'h00FF);
        rst = 1'b0;
        tick;
        chk("idle_oam_we", {15'd0, oam_we}, 16'd0);
        chk("idle_bus_rd", {15'd0, bus_rd}, 16'd0);
        chk("idle_bus_we", {15'd0, bus_we}, 16'd0);

        cpu_addr = 16'h1234; cpu_wdata = 8'h55; cpu_we = 1'b1; #1;
        chk("pass_bus_we", {15'd0, bus_we}, 16'd1);
        chk("pass_bus_addr", bus_addr, 16'h1234);
        chk("pass_bus_wdata", {8'h00, bus_wdata}, 16'h0055);
        cpu_addr = 16'hFF80; #1;
        chk("hi_write_no_strobe", {15'd0, bus_we}, 16'd0);
        tick; cpu_we = 1'b0;
        cpu_rdx(16'h0150, rom(16'h0150), 1'b1);

        // full transfer from page 00 with blocked main read and high read mid-way
        push_xfer(8'h00, 160);
        c0 = oam_cnt;
        cpu_wr(16'hFF46, 8'h00);
        chk("dma_active_rise", {15'd0, dma_active}, 16'd1);
        n = 0;
        while (dma_active && n < 400) begin
            if (n == 10) cpu_rdx(16'h0150, 8'hFF, 1'b0);
            else if (n == 20) cpu_rdx(16'hFF80, 8'hA7, 1'b0);
            else tick;
            n++;
        end
        chk("active_cycles_p00", 16'(n), 16'd162);
        chk("oam_pulses_p00", 16'(oam_cnt - c0), 16'd160);
        cpu_rdx(16'h0150, rom(16'h0150), 1'b1);
        cpu_rdx(16'hFF46, 8'h00, 1'b0);

        // page adjust: E3 sources from C3
        push_xfer(8'hC3, 160);
        cpu_wr(16'hFF46, 8'hE3);
        n = 0; k = 0; bad = 0;
        while (dma_active && n < 400) begin
            if (bus_rd) begin
                if (bus_addr != {8'hC3, 8'(k)}) bad++;
                k++;
            end
            tick;
            n++;
        end
        chk("adj_read_count", 16'(k), 16'd160);
        chk("adj_addr_errors", 16'(bad), 16'd0);
        cpu_rdx(16'hFF46, 8'hE3, 1'b0);

        // restart at i=50: OAM[0..50] from page 00, then a full page 01 copy
        push_xfer(8'h00, 51);
        push_xfer(8'h01, 160);
        cpu_wr(16'hFF46, 8'h00);
        n = 0; found = 1'b0;
        while (dma_active && n < 600) begin
            if (!found && bus_rd && bus_addr == 16'h0032) begin
                found = 1'b1;
                cpu_wr(16'hFF46, 8'h01);
            end else tick;
            n++;
        end
        chk("restart_found_i50", {15'd0, found}, 16'd1);
        chk("restart_active_cycles", 16'(n), 16'd214);
        bad = 0;
        for (int i = 0; i < 160; i++) if (oam_m[i] != rom({8'h01, 8'(i)})) bad++;
        chk("restart_final_oam", 16'(bad), 16'd0);

        // reset at i=80 aborts; OAM[79..159] keep page 01 contents
        push_xfer(8'h02, 79);
        c0 = oam_cnt;
        cpu_wr(16'hFF46, 8'h02);
        n = 0;
        while (n < 400 && !(bus_rd && bus_addr == 16'h0250)) begin
            tick;
            n++;
        end
        chk("abort_found_i80", {15'd0, n < 400}, 16'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_dma_active", {15'd0, dma_active}, 16'd0);
        chk("abort_oam_we", {15'd0, oam_we}, 16'd0);
        repeat (5) tick;
        chk("abort_oam_pulses", 16'(oam_cnt - c0), 16'd79);
        bad = 0;
        for (int i = 79; i < 160; i++) if (oam_m[i] != rom({8'h01, 8'(i)})) bad++;
        chk("abort_oam_untouched", 16'(bad), 16'd0);

        // write and read of the register together: write wins, no data phase
        push_xfer(8'h05, 160);
        cpu_addr = 16'hFF46; cpu_wdata = 8'h05; cpu_we = 1'b1; cpu_rd = 1'b1;
        tick;
        cpu_we = 1'b0; cpu_rd = 1'b0;
        chk("wr_rd_no_data", {8'h00, cpu_rdata}, 16'h00FF);
        n = 0;
        while (dma_active && n < 400) begin
            tick;
            n++;
        end
        chk("active_cycles_p05", 16'(n), 16'd162);
        repeat (3) tick;
        chk("oam_queue_drained", 16'(oam_exp_q.size()), 16'd0);
        chk("rd_queue_drained", 16'(rd_exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
